// File: rtl/booth_r8_pkg.sv
// Shared types and the radix-8 Booth window encoder for the partial-product sequencer.
// Selection is one-hot over the 1X/2X/3X/4X multiples, plus a separate sign bit.
package booth_r8_pkg;

   typedef struct packed {
      logic x4;
      logic x3;
      logic x2;
      logic x1;
      logic neg;
   } booth_sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      EMIT = 2'd2
   } booth_state_e;

   // Window bits are {y[3i+2], y[3i+1], y[3i], y[3i-1]}; 0000 and 1111 both encode zero.
   function automatic booth_sel_t booth_encode(input logic [3:0] w);
      booth_sel_t s;
      s = '0;
      case (w)
         4'b0001, 4'b0010, 4'b1101, 4'b1110: s.x1 = 1'b1;
         4'b0011, 4'b0100, 4'b1011, 4'b1100: s.x2 = 1'b1;
         4'b0101, 4'b0110, 4'b1001, 4'b1010: s.x3 = 1'b1;
         4'b0111, 4'b1000:                   s.x4 = 1'b1;
         default: ;
      endcase
      s.neg = w[3] & ~(&w[2:0]);
      return s;
   endfunction

endpackage

// File: rtl/booth_r8_encoder.sv
// Combinational radix-8 Booth encoder: 4-bit multiplier window to one-hot multiple select.
module booth_r8_encoder
   import booth_r8_pkg::*;
(
   input  logic [3:0] win,
   output booth_sel_t sel
);

   assign sel = booth_encode(win);

endmodule

// File: rtl/booth_r8_pp_sequencer.sv
// Iterative radix-8 Booth partial-product sequencer: one operand pair in, one row per handshake out.
// Optional macro BOOTH_ZERO_SKIP_EN drops rows whose Booth digit is zero.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand pair
//   PREP  | build 3X, load row 0 (or first non-zero row) onto the outputs
//   EMIT  | hold current row until pp_ready, then load next row or return to IDLE
module booth_r8_pp_sequencer
   import booth_r8_pkg::*;
#(
   parameter  int WIDTH  = 24,
   localparam int PP_W   = WIDTH + 3,
   localparam int NUM_PP = (WIDTH + 2) / 3,
   localparam int IDX_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  x_in,
   input  logic [WIDTH-1:0]  y_in,
   output logic              pp_valid,
   input  logic              pp_ready,
   output logic [PP_W-1:0]   pp,
   output logic              pp_neg,
   output logic [IDX_W-1:0]  pp_idx,
   output logic              pp_last
);

   localparam int YW = 3 * NUM_PP;

   booth_state_e      state_q, state_d;
   logic [WIDTH-1:0]  x_q;
   logic [YW-1:0]     y_q;
   logic [PP_W-1:0]   x3_q;
   logic [PP_W-1:0]   pp_q;
   logic              neg_q, last_q, valid_q;
   logic [IDX_W-1:0]  idx_q;

   logic              load, clear, ld_last;
   logic [IDX_W-1:0]  scan_start, ld_idx;
   logic [YW:0]       y_ext;
   logic [NUM_PP-1:0] nz;
   logic [3:0]        ld_win;
   booth_sel_t        ld_sel;
   logic [PP_W-1:0]   x1, x2, x3, x4, mag, row;

   assign y_ext = {y_q, 1'b0};
   assign x1    = PP_W'($signed(x_q));
   assign x2    = x1 << 1;
   assign x4    = x1 << 2;
   // Row 0 is loaded in the same cycle 3X is registered, so bypass the register then.
   assign x3    = (state_q == PREP) ? (x1 + x2) : x3_q;

   always_comb begin
      nz = '0;
      for (int i = 0; i < NUM_PP; i++)
         nz[i] = (y_ext[3*i +: 4] != 4'b0000) && (y_ext[3*i +: 4] != 4'b1111);
   end

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      clear      = 1'b0;
      scan_start = '0;
      case (state_q)
         IDLE: if (in_valid) state_d = PREP;
         PREP: begin
            load    = 1'b1;
            state_d = EMIT;
         end
         EMIT: if (pp_ready) begin
            if (last_q) begin
               clear   = 1'b1;
               state_d = IDLE;
            end else begin
               load       = 1'b1;
               scan_start = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef BOOTH_ZERO_SKIP_EN
   // An all-zero multiplier still produces one (zero) row, tagged with the top index.
   always_comb begin
      ld_idx = IDX_W'(NUM_PP - 1);
      for (int i = NUM_PP - 1; i >= 0; i--)
         if (nz[i] && (i >= int'(scan_start))) ld_idx = IDX_W'(i);
      ld_last = 1'b1;
      for (int i = 0; i < NUM_PP; i++)
         if (nz[i] && (i > int'(ld_idx))) ld_last = 1'b0;
   end
`else
   assign ld_idx  = scan_start;
   assign ld_last = (scan_start == IDX_W'(NUM_PP - 1));
`endif

   always_comb begin
      ld_win = '0;
      for (int i = 0; i < NUM_PP; i++)
         if (ld_idx == IDX_W'(i)) ld_win = y_ext[3*i +: 4];
   end

   booth_r8_encoder u_enc (
      .win (ld_win),
      .sel (ld_sel)
   );

   assign mag = ({PP_W{ld_sel.x1}} & x1) | ({PP_W{ld_sel.x2}} & x2) |
                ({PP_W{ld_sel.x3}} & x3) | ({PP_W{ld_sel.x4}} & x4);
   assign row = mag ^ {PP_W{ld_sel.neg}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         x3_q    <= '0;
         pp_q    <= '0;
         neg_q   <= 1'b0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && in_valid) begin
            x_q <= x_in;
            y_q <= YW'($signed(y_in));
         end
         if (state_q == PREP) x3_q <= x3;
         if (load) begin
            pp_q    <= row;
            neg_q   <= ld_sel.neg;
            idx_q   <= ld_idx;
            last_q  <= ld_last;
            valid_q <= 1'b1;
         end else if (clear) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign in_ready = (state_q == IDLE);
   assign pp_valid = valid_q;
   assign pp       = pp_q;
   assign pp_neg   = neg_q;
   assign pp_idx   = idx_q;
   assign pp_last  = last_q;

endmodule

// File: tb/tb_booth_r8_pp_sequencer.sv
// Scoreboard bench for booth_r8_pp_sequencer (WIDTH=24): expected rows and products are queued
// at issue time and checked by an independent monitor on every pp handshake.
module tb_booth_r8_pp_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] x_in = '0;
   logic [23:0] y_in = '0;
   logic        pp_valid;
   logic        pp_ready = 1'b1;
   logic [26:0] pp;
   logic        pp_neg;
   logic [2:0]  pp_idx;
   logic        pp_last;

   typedef struct packed {
      logic [26:0] pp;
      logic        neg;
      logic [2:0]  idx;
      logic        last;
   } row_t;

   row_t        exp_q[$];
   logic [50:0] prod_q[$];
   int          errors = 0;
   int          checks = 0;

   booth_r8_pp_sequencer #(.WIDTH(24)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_in     (x_in),
      .y_in     (y_in),
      .pp_valid (pp_valid),
      .pp_ready (pp_ready),
      .pp       (pp),
      .pp_neg   (pp_neg),
      .pp_idx   (pp_idx),
      .pp_last  (pp_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_row(input logic [26:0] p, input logic n, input int idx, input logic last);
      row_t r;
      r.pp   = p;
      r.neg  = n;
      r.idx  = 3'(idx);
      r.last = last;
      exp_q.push_back(r);
   endtask

   task automatic push_prod(input logic [23:0] x, input logic [23:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      prod_q.push_back(p[50:0]);
   endtask

   // Reference digits from the arithmetic definition d = -4a + 2b + c + e.
   task automatic push_model(input logic [23:0] x, input logic [23:0] y);
      logic [24:0] ye;
      logic [3:0]  w;
      int          d;
      longint      m;
      logic [26:0] mg;
      row_t        rows[$];
      row_t        r;
      ye = {y, 1'b0};
      for (int i = 0; i < 8; i++) begin
         w  = ye[3*i +: 4];
         d  = -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
         m  = longint'($signed(x)) * longint'((d < 0) ? -d : d);
         mg = m[26:0];
         r.pp   = (d < 0) ? ~mg : mg;
         r.neg  = (d < 0);
         r.idx  = 3'(i);
         r.last = 1'b0;
`ifdef BOOTH_ZERO_SKIP_EN
         if (d != 0) rows.push_back(r);
`else
         rows.push_back(r);
`endif
      end
      if (rows.size() == 0) begin
         r = '0;
         r.idx = 3'd7;
         rows.push_back(r);
      end
      rows[rows.size()-1].last = 1'b1;
      foreach (rows[k]) exp_q.push_back(rows[k]);
      push_prod(x, y);
   endtask

   task automatic send(input logic [23:0] x, input logic [23:0] y);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      x_in = x;
      y_in = y;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || pp_valid) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(exp_q.size() == 0 && !pp_valid && prod_q.size() == 0), 64'd1);
   endtask

   task automatic wait_row(input int idx);
      int n = 0;
      while (!(pp_valid && pp_idx == 3'(idx)) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("reach_row%0d", idx), 64'(pp_valid && pp_idx == 3'(idx)), 64'd1);
   endtask

   // Monitor: compare every accepted row and the reconstructed product on the last row.
   initial begin
      logic [50:0] acc;
      logic [50:0] t;
      row_t        e;
      acc = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc = '0;
            exp_q.delete();
            prod_q.delete();
         end else if (pp_valid && pp_ready) begin
            if (exp_q.size() == 0) begin
               check("row_unexpected", {pp, pp_neg, pp_idx, pp_last}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("row%0d", e.idx), {pp, pp_neg, pp_idx, pp_last}, e);
            end
            t   = {{24{pp[26]}}, pp} + 51'(pp_neg);
            acc = acc + (t << (3 * pp_idx));
            if (pp_last) begin
               if (prod_q.size() == 0) check("product_unexpected", 64'(acc), 64'd0);
               else                    check("product", 64'(acc), 64'(prod_q.pop_front()));
               acc = '0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [26:0] s_pp;
      logic [2:0]  s_idx;
      logic        s_neg;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_pp_valid", 64'(pp_valid), 64'd0);
      check("rst_pp",       64'(pp),       64'd0);
      check("rst_pp_idx",   64'(pp_idx),   64'd0);
      check("rst_pp_neg",   64'(pp_neg),   64'd0);
      check("rst_pp_last",  64'(pp_last),  64'd0);

      // X=1, Y=1 with latency check
`ifdef BOOTH_ZERO_SKIP_EN
      push_row(27'h1, 1'b0, 0, 1'b1);
`else
      push_row(27'h1, 1'b0, 0, 1'b0);
      for (int i = 1; i < 8; i++) push_row(27'h0, 1'b0, i, i == 7);
`endif
      push_prod(24'd1, 24'd1);
      send(24'd1, 24'd1);
      check("lat_cycle1_valid", 64'(pp_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_cycle2_valid", 64'(pp_valid), 64'd1);
      wait_done("drain_1x1");

      // X=5, Y=-1
`ifdef BOOTH_ZERO_SKIP_EN
      push_row(27'h7FFFFFA, 1'b1, 0, 1'b1);
`else
      push_row(27'h7FFFFFA, 1'b1, 0, 1'b0);
      for (int i = 1; i < 8; i++) push_row(27'h0, 1'b0, i, i == 7);
`endif
      push_prod(24'd5, 24'hFFFFFF);
      send(24'd5, 24'hFFFFFF);
      wait_done("drain_5xm1");

      // X=5, Y=4: digit -4 then +1
`ifdef BOOTH_ZERO_SKIP_EN
      push_row(27'h7FFFFEB, 1'b1, 0, 1'b0);
      push_row(27'd5, 1'b0, 1, 1'b1);
`else
      push_row(27'h7FFFFEB, 1'b1, 0, 1'b0);
      push_row(27'd5, 1'b0, 1, 1'b0);
      for (int i = 2; i < 8; i++) push_row(27'h0, 1'b0, i, i == 7);
`endif
      push_prod(24'd5, 24'd4);
      send(24'd5, 24'd4);
      wait_done("drain_5x4");

      // Y=0x200: only digit 3 is non-zero (+1)
`ifdef BOOTH_ZERO_SKIP_EN
      push_row(27'h0ABCDE, 1'b0, 3, 1'b1);
`else
      for (int i = 0; i < 8; i++) push_row((i == 3) ? 27'h0ABCDE : 27'h0, 1'b0, i, i == 7);
`endif
      push_prod(24'h0ABCDE, 24'h000200);
      send(24'h0ABCDE, 24'h000200);
      wait_done("drain_y200");

      // Extremes and mixed vectors
      push_model(24'h800000, 24'h800000);
      send(24'h800000, 24'h800000);
      wait_done("drain_min_min");

      push_model(24'h800000, 24'h7FFFFF);
      send(24'h800000, 24'h7FFFFF);
      wait_done("drain_min_max");

      push_model(24'h123456, 24'hFEDCBA);
      send(24'h123456, 24'hFEDCBA);
      wait_done("drain_mixed");

      push_model(24'hFFFFF9, 24'h000000);
      send(24'hFFFFF9, 24'h000000);
      wait_done("drain_y0");

      // Backpressure on row 2
      push_model(24'h000123, 24'h249249);
      send(24'h000123, 24'h249249);
      wait_row(2);
      pp_ready = 1'b0;
      s_pp  = pp;
      s_idx = pp_idx;
      s_neg = pp_neg;
      repeat (3) begin
         @(posedge clk); #1;
         check("stall_pp",       64'(pp),       64'(s_pp));
         check("stall_idx",      64'(pp_idx),   64'(s_idx));
         check("stall_neg",      64'(pp_neg),   64'(s_neg));
         check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      pp_ready = 1'b1;
      wait_done("drain_stall");

      // Reset while row 4 is presented
      push_model(24'd7, 24'h249249);
      send(24'd7, 24'h249249);
      wait_row(4);
      pp_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_pp_valid", 64'(pp_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      pp_ready = 1'b1;
      push_model(24'hFFFFFD, 24'h654321);
      send(24'hFFFFFD, 24'h654321);
      wait_done("drain_after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
